// File: rtl/gpp_txrx_pkg.sv
// Shared lane-format helpers for the GPP photonic transmit/receive blocks.
// A lane is {vld, dest, src, data} with data in the least significant bits.
// Offsets are functions of the id/payload widths so every block agrees on layout.
package gpp_txrx_pkg;

   // Payload always starts at bit 0 of a lane.
   localparam int OFF_DATA = 0;

   // Total lane width: valid bit, destination id, source id, payload.
   function automatic int lane_w(input int id_w, input int data_w);
      return 1 + 2 * id_w + data_w;
   endfunction

   // Source id sits directly above the payload.
   function automatic int off_src(input int id_w, input int data_w);
      return data_w + 0 * id_w;
   endfunction

   // Destination id sits above the source id.
   function automatic int off_dest(input int id_w, input int data_w);
      return data_w + id_w;
   endfunction

   // Valid bit is the lane MSB.
   function automatic int off_vld(input int id_w, input int data_w);
      return data_w + 2 * id_w;
   endfunction

endpackage

// File: rtl/rx_lane_fifo.sv
// Single-lane receive FIFO holding {src, data} entries.
// Latency: a pushed entry is visible at rdata the cycle after the push edge.
// Backpressure: push into a full FIFO is ignored unless a pop frees a slot in the same cycle.
module rx_lane_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         empty,
   output logic         full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign rdata = mem_q[rd_ptr_q];

   // A pop on an empty FIFO is meaningless; a pop frees the slot a full-FIFO push needs.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Occupancy changes only when exactly one of push/pop takes effect.
   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)
         count_d = count_q + 1'b1;
      else if (do_pop && !do_push)
         count_d = count_q - 1'b1;
   end

   // Pointers wrap naturally modulo DEPTH since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/rx_multichannel_buffer.sv
// Multi-lane WDM receiver: captures packets addressed to this node into per-lane FIFOs.
// Latency: capture 1 cycle into FIFO; read data/valid registered, 1 cycle after rd_en.
// Backpressure: none upstream; packets hitting a full lane are dropped and flagged in ovf.
module rx_multichannel_buffer
   import gpp_txrx_pkg::*;
#(
   parameter int ID_W   = 2,
   parameter int DATA_W = 8,
   parameter int CH     = 4,
   parameter int DEPTH  = 4,
   parameter int BCAST  = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [CH*lane_w(ID_W, DATA_W)-1:0]     rx_in,
   input  logic [ID_W-1:0]                        id,
   input  logic                                   rtr_write_enable,
   input  logic                                   rd_en,
   input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] rd_ch,
   input  logic                                   ovf_clr,
   output logic [CH-1:0]                          flag_res,
   output logic [CH-1:0]                          full,
   output logic [CH-1:0]                          ovf,
   output logic [DATA_W-1:0]                      data_out,
   output logic [ID_W-1:0]                        src_out,
   output logic                                   data_valid,
   output logic                                   rd_err
);
   localparam int LW = lane_w(ID_W, DATA_W);
   localparam int EW = ID_W + DATA_W;
   localparam int VO = off_vld(ID_W, DATA_W);
   localparam int DO = off_dest(ID_W, DATA_W);

   logic [CH-1:0]     match, lane_empty, lane_full, pop_vec, ovf_new;
   logic [EW-1:0]     lane_rdata [CH];
   logic [EW-1:0]     head;
   logic              rd_hit, rd_ok;
   logic [CH-1:0]     ovf_q, ovf_d;
   logic [DATA_W-1:0] data_q;
   logic [ID_W-1:0]   src_q;
   logic              dv_q, err_q;

   for (genvar k = 0; k < CH; k++) begin : g_lane
      logic [LW-1:0]   lane;
      logic [ID_W-1:0] dest;
      assign lane = rx_in[k*LW +: LW];
      assign dest = lane[DO +: ID_W];
      // Unicast hit on our id, or broadcast when enabled.
      assign match[k] = lane[VO] & rtr_write_enable &
                        ((dest == id) | ((BCAST != 0) & (dest == '1)));
      rx_lane_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (match[k]),
         .pop   (pop_vec[k]),
         .wdata (lane[OFF_DATA +: EW]),
         .rdata (lane_rdata[k]),
         .empty (lane_empty[k]),
         .full  (lane_full[k])
      );
   end

   assign flag_res = ~lane_empty;
   assign full     = lane_full;

   // Select the requested lane; an out-of-range rd_ch selects nothing and reads as empty.
   always_comb begin
      rd_hit  = 1'b0;
      head    = '0;
      pop_vec = '0;
      for (int k = 0; k < CH; k++) begin
         if (int'(rd_ch) == k) begin
            rd_hit     = ~lane_empty[k];
            head       = lane_rdata[k];
            pop_vec[k] = rd_en & ~lane_empty[k];
         end
      end
      rd_ok = rd_en & rd_hit;
   end

   // A drop only happens when the lane is full and not being drained this cycle.
   always_comb begin
      ovf_new = match & lane_full & ~pop_vec;
      ovf_d   = (ovf_q & ~{CH{ovf_clr}}) | ovf_new;
   end

   // Sticky overflow bits and the registered read port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q  <= '0;
         data_q <= '0;
         src_q  <= '0;
         dv_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         dv_q  <= rd_ok;
         err_q <= rd_en & ~rd_ok;
         if (rd_ok) begin
            data_q <= head[DATA_W-1:0];
            src_q  <= head[DATA_W +: ID_W];
         end
      end
   end

   assign ovf        = ovf_q;
   assign data_out   = data_q;
   assign src_out    = src_q;
   assign data_valid = dv_q;
   assign rd_err     = err_q;

endmodule
